cache_plru_ctrl: RTL



---
 rtl/cache_plru_pkg.sv | 29 ++
 rtl/cache_plru_tree.sv | 58 +++++
 rtl/cache_plru_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/cache_plru_pkg.sv
// Shared types and default geometry for the per-set PLRU replacement controller.
package cache_plru_pkg;

  localparam int unsigned DEF_SETS     = 16;
  localparam int unsigned DEF_SET_BITS = 4;
  localparam int unsigned DEF_WAYS     = 8;
  localparam int unsigned DEF_WAYS_REP = 3;

  // Request opcodes as encoded on req_op.
  typedef enum logic [1:0] {
    OP_HIT   = 2'b00,
    OP_MISS  = 2'b01,
    OP_INVAL = 2'b10,
    OP_FLUSH = 2'b11
  } plru_op_e;

  // Controller sequencing states.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    LOOKUP = 2'b01,
    UPDATE = 2'b10,
    FLUSH  = 2'b11
  } plru_state_e;

  // Tree update mode: touch points path nodes away from a way, target toward it.
  localparam logic MODE_TOUCH  = 1'b0;
  localparam logic MODE_TARGET = 1'b1;

endpackage

// File: rtl/cache_plru_tree.sv
// Combinational PLRU tree helper: path update (touch/target) and victim walk.
// Node 0 is the root, node n has children 2n+1 / 2n+2; a node bit of 0 means
// the victim lies in the left subtree, 1 means the right subtree.
module cache_plru_tree
  import cache_plru_pkg::*;
#(
  parameter int unsigned WAYS     = DEF_WAYS,
  parameter int unsigned WAYS_REP = DEF_WAYS_REP
) (
  input  logic [WAYS-2:0]     plru_i,
  input  logic [WAYS_REP-1:0] way_i,
  input  logic                mode_i,
  output logic [WAYS-2:0]     plru_o,
  output logic [WAYS_REP-1:0] victim_o
);

  // Index of the child reached from node n by taking direction b.
  function automatic logic [WAYS_REP-1:0] child(input logic [WAYS_REP-1:0] n,
                                                input logic b);
    logic [WAYS_REP:0] nxt;
    nxt = {n, 1'b1} + {{WAYS_REP{1'b0}}, b};
    return nxt[WAYS_REP-1:0];
  endfunction

  // Rewrite every node on way_i's path (MSB of the way selects at the root).
  always_comb begin
    logic [WAYS_REP-1:0] node;
    logic [WAYS_REP-1:0] wsh;
    logic                dir;
    plru_o = plru_i;
    node   = '0;
    wsh    = way_i;
    dir    = 1'b0;
    for (int unsigned l = 0; l < WAYS_REP; l++) begin
      dir          = wsh[WAYS_REP-1];
      plru_o[node] = (mode_i == MODE_TARGET) ? dir : ~dir;
      node         = child(node, dir);
      wsh          = wsh << 1;
    end
  end

  // Follow the node bits from the root; each step contributes one way bit.
  always_comb begin
    logic [WAYS_REP-1:0] node;
    logic [WAYS_REP-1:0] vic;
    logic                dir;
    node = '0;
    vic  = '0;
    dir  = 1'b0;
    for (int unsigned l = 0; l < WAYS_REP; l++) begin
      dir  = plru_i[node];
      vic  = (vic << 1) | WAYS_REP'(dir);
      node = child(node, dir);
    end
    victim_o = vic;
  end

endmodule

// File: rtl/cache_plru_ctrl.sv
// Per-set PLRU replacement-state controller for an 8-way set-associative cache.
// Holds tree bits and way-valid bits for every set and serves one request at a
// time as a read-modify-write (HIT/MISS/INVAL) or a sequential sweep (FLUSH).
// Optional hit/miss counters are built when CACHE_PLRU_STATS_EN is defined.
module cache_plru_ctrl
  import cache_plru_pkg::*;
#(
  parameter int unsigned SETS     = DEF_SETS,
  parameter int unsigned SET_BITS = DEF_SET_BITS,
  parameter int unsigned WAYS     = DEF_WAYS,
  parameter int unsigned WAYS_REP = DEF_WAYS_REP
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [1:0]          req_op,
  input  logic [SET_BITS-1:0] req_set,
  input  logic [WAYS_REP-1:0] req_way,
  output logic                rsp_valid,
  output logic [WAYS_REP-1:0] rsp_way,
  output logic                rsp_evict,
  output logic                rsp_err
`ifdef CACHE_PLRU_STATS_EN
  ,
  output logic [15:0]         hit_cnt,
  output logic [15:0]         miss_cnt
`endif
);

  plru_state_e         state_q, state_d;
  plru_op_e            op_q;
  logic [SET_BITS-1:0] set_q;
  logic [WAYS_REP-1:0] way_q;
  logic [WAYS-2:0]     cur_plru_q;
  logic [WAYS-1:0]     cur_valid_q;
  logic [WAYS_REP-1:0] victim_q;
  logic                evict_q;
  logic [SET_BITS-1:0] flush_cnt_q;

  logic [WAYS-2:0]     plru_q  [SETS];
  logic [WAYS-1:0]     valid_q [SETS];

  logic                accept;
  logic                flush_last;
  logic [WAYS-2:0]     lk_plru;
  logic [WAYS-1:0]     lk_valid;
  logic [WAYS_REP-1:0] lk_victim;
  logic                lk_evict;
  logic [WAYS_REP-1:0] first_inv;
  logic                any_inv;

  logic [WAYS-2:0]     tree_plru_in;
  logic [WAYS_REP-1:0] tree_way;
  logic                tree_mode;
  logic [WAYS-2:0]     tree_plru_out;
  logic [WAYS_REP-1:0] tree_victim;

  logic                wr_en;
  logic [SET_BITS-1:0] wr_set;
  logic [WAYS-2:0]     wr_plru_d;
  logic [WAYS-1:0]     wr_valid_d;
  logic [WAYS-1:0]     way_onehot;

  assign accept     = req_valid && (state_q == IDLE);
  assign flush_last = (flush_cnt_q == SET_BITS'(SETS - 1));
  assign lk_plru    = plru_q[set_q];
  assign lk_valid   = valid_q[set_q];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = (plru_op_e'(req_op) == OP_FLUSH) ? FLUSH : LOOKUP;
      end
      LOOKUP:  state_d = UPDATE;
      UPDATE:  state_d = IDLE;
      FLUSH:   if (flush_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Response outputs are decoded from state and the registered lookup results.
  always_comb begin
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == UPDATE) || ((state_q == FLUSH) && flush_last);
    rsp_way   = (state_q == UPDATE) ? tree_way : '0;
    rsp_evict = (state_q == UPDATE) && (op_q == OP_MISS) && evict_q;
    rsp_err   = (state_q == UPDATE) && (op_q == OP_HIT) && !cur_valid_q[way_q];
  end

  // Capture the request on accept; snapshot the set and choose a victim in LOOKUP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q        <= OP_HIT;
      set_q       <= '0;
      way_q       <= '0;
      cur_plru_q  <= '0;
      cur_valid_q <= '0;
      victim_q    <= '0;
      evict_q     <= 1'b0;
    end else begin
      if (accept) begin
        op_q  <= plru_op_e'(req_op);
        set_q <= req_set;
        way_q <= req_way;
      end
      if (state_q == LOOKUP) begin
        cur_plru_q  <= lk_plru;
        cur_valid_q <= lk_valid;
        victim_q    <= lk_victim;
        evict_q     <= lk_evict;
      end
    end
  end

  // Flush sweep counter; wraps to zero after the last set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                flush_cnt_q <= '0;
    else if (state_q == FLUSH) flush_cnt_q <= flush_cnt_q + 1'b1;
  end

  // Lowest-index invalid way of the looked-up set.
  always_comb begin
    first_inv = '0;
    any_inv   = 1'b0;
    for (int unsigned i = 0; i < WAYS; i++) begin
      if (!lk_valid[i] && !any_inv) begin
        first_inv = WAYS_REP'(i);
        any_inv   = 1'b1;
      end
    end
    lk_evict  = !any_inv;
    lk_victim = any_inv ? first_inv : tree_victim;
  end

  // One tree instance is shared: it walks the live set in LOOKUP and rewrites
  // the snapshot in UPDATE, so its plru input is muxed by state.
  always_comb begin
    tree_plru_in = (state_q == LOOKUP) ? lk_plru : cur_plru_q;
    tree_way     = (op_q == OP_MISS) ? victim_q : way_q;
    tree_mode    = (op_q == OP_INVAL) ? MODE_TARGET : MODE_TOUCH;
  end

  cache_plru_tree #(
    .WAYS     (WAYS),
    .WAYS_REP (WAYS_REP)
  ) u_tree (
    .plru_i   (tree_plru_in),
    .way_i    (tree_way),
    .mode_i   (tree_mode),
    .plru_o   (tree_plru_out),
    .victim_o (tree_victim)
  );

  // Write-back port: the updated set in UPDATE, or one cleared set per FLUSH cycle.
  always_comb begin
    way_onehot = WAYS'(1) << tree_way;
    wr_en      = 1'b0;
    wr_set     = set_q;
    wr_plru_d  = tree_plru_out;
    wr_valid_d = cur_valid_q;
    if (state_q == UPDATE) begin
      wr_en = 1'b1;
      if (op_q == OP_MISS)  wr_valid_d = cur_valid_q | way_onehot;
      if (op_q == OP_INVAL) wr_valid_d = cur_valid_q & ~way_onehot;
    end else if (state_q == FLUSH) begin
      wr_en      = 1'b1;
      wr_set     = flush_cnt_q;
      wr_plru_d  = '0;
      wr_valid_d = '0;
    end
  end

  // Per-set replacement state storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        plru_q[s]  <= '0;
        valid_q[s] <= '0;
      end
    end else if (wr_en) begin
      plru_q[wr_set]  <= wr_plru_d;
      valid_q[wr_set] <= wr_valid_d;
    end
  end

`ifdef CACHE_PLRU_STATS_EN
  logic [15:0] hit_cnt_q, hit_cnt_d;
  logic [15:0] miss_cnt_q, miss_cnt_d;

  // Saturating hit/miss counters, cleared when a flush completes.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if ((state_q == FLUSH) && flush_last) begin
      hit_cnt_d  = '0;
      miss_cnt_d = '0;
    end else if (state_q == UPDATE) begin
      if ((op_q == OP_HIT) && (hit_cnt_q != '1))   hit_cnt_d  = hit_cnt_q + 16'd1;
      if ((op_q == OP_MISS) && (miss_cnt_q != '1)) miss_cnt_d = miss_cnt_q + 16'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule
